// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: state encoding, port ids and default latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } arb_state_t;

  localparam logic PORT_IF   = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  localparam int MEM_LAT_DEFAULT = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch and data requesters.
// MEM_PORT_ARBITER_DATA_PRIO_EN: on a tie the data port always wins instead of round-robin.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);

`ifdef MEM_PORT_ARBITER_DATA_PRIO_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
`endif

  always_comb begin
    valid  = if_req | d_req;
    winner = PORT_IF;
    if (if_req && d_req) begin
`ifdef MEM_PORT_ARBITER_DATA_PRIO_EN
      winner = PORT_DATA;
`else
      winner = ~last_gnt;
`endif
    end else if (d_req) begin
      winner = PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) req/done arbiter in front of a single-port memory with fixed read latency.
// MEM_PORT_ARBITER_DATA_PRIO_EN: data port wins ties (see mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt_id
);

  arb_state_t    state, state_nxt;
  logic          last_gnt;
  logic          gnt;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    cnt;
  logic [DW-1:0] cap_q;
  logic [DW-1:0] if_hold;
  logic [DW-1:0] d_hold;
  logic          pick_valid;
  logic          pick_id;

  mem_arb_pick u_pick (
    .if_req   (if_req),
    .d_req    (d_req),
    .last_gnt (last_gnt),
    .valid    (pick_valid),
    .winner   (pick_id)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = we_q ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      gnt      <= PORT_IF;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      cap_q    <= '0;
      if_hold  <= '0;
      d_hold   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt      <= pick_id;
            last_gnt <= pick_id;
            addr_q   <= (pick_id == PORT_DATA) ? d_addr : if_addr;
            we_q     <= (pick_id == PORT_DATA) && d_we;
            wdata_q  <= (pick_id == PORT_DATA) ? d_wdata : '0;
          end
        end
        ISSUE: begin
          if (!we_q) cnt <= 4'(MEM_LAT);
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) cap_q <= mem_rdata;
        end
        default: begin
          if (gnt == PORT_IF) if_hold <= cap_q;
          else                d_hold  <= cap_q;
        end
      endcase
    end
  end

  // Holding registers stay on the bus through WAIT/RESP; bus is parked at zero only in IDLE.
  assign mem_addr  = (state == IDLE) ? '0 : addr_q;
  assign mem_wdata = (state == IDLE) ? '0 : wdata_q;
  assign mem_re    = (state == ISSUE) && !we_q;
  assign mem_we    = (state == ISSUE) && we_q;
  assign busy      = (state != IDLE);
  assign gnt_id    = gnt;
  assign if_done   = (state == RESP) && (gnt == PORT_IF);
  assign d_done    = (state == RESP) && (gnt == PORT_DATA);
  assign if_rdata  = if_done ? cap_q : if_hold;
  assign d_rdata   = d_done ? cap_q : d_hold;

  req_held_a: assert property (@(posedge clk) disable iff (rst)
    ((state == ISSUE || state == WAIT) |-> ((gnt == PORT_IF) ? if_req : d_req)))
    else $error("requester dropped req before done");

  strobe_excl_a: assert property (@(posedge clk) disable iff (rst) !(mem_re && mem_we))
    else $error("mem_re and mem_we high together");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT=1 instance plus a MEM_LAT=3 instance).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        mem_init;
  int          checks;
  int          errors;

  logic        if_req, d_req, d_we;
  logic [7:0]  if_addr, d_addr;
  logic [15:0] d_wdata;
  logic [15:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic        if_done, d_done, mem_re, mem_we, busy, gnt_id;
  logic [7:0]  mem_addr;

  logic        if_req3, d_req3, d_we3;
  logic [7:0]  if_addr3, d_addr3;
  logic [15:0] d_wdata3;
  logic [15:0] if_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic        if_done3, d_done3, mem_re3, mem_we3, busy3, gnt_id3;
  logic [7:0]  mem_addr3;

  logic [15:0] mem [256];
  logic [15:0] p3 [3];

  mem_port_arbiter #(.AW(8), .DW(16), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
  );

  mem_port_arbiter #(.AW(8), .DW(16), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_done(if_done3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_rdata(d_rdata3), .d_done(d_done3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_re(mem_re3), .mem_we(mem_we3),
    .mem_rdata(mem_rdata3), .busy(busy3), .gnt_id(gnt_id3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'h1234 : {~a, a};
  endfunction

  // Memory model: read data appears exactly MEM_LAT cycles after the mem_re cycle, junk otherwise.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always @(posedge clk) mem_rdata <= mem_re ? mem[mem_addr] : 16'hDEAD;

  always @(posedge clk) begin
    p3[0] <= mem_re3 ? mem[mem_addr3] : 16'hDEAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata3 = p3[2];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_init = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    if_req3 = 0; if_addr3 = 0; d_req3 = 0; d_we3 = 0; d_addr3 = 0; d_wdata3 = 0;
    #2;
    checks++;
    if ({busy, mem_re, mem_we, if_done, d_done, gnt_id} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000000", {busy, mem_re, mem_we, if_done, d_done, gnt_id});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 56'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
    end
    tick(); tick();
    mem_init = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch;
    if_req = 1; if_addr = 8'h10;
    checks++;
    if (mem_addr !== 8'h00) begin errors++; $display("FAIL fetch_idle_addr got %h exp 00", mem_addr); end
    tick();
    checks++;
    if ({mem_re, mem_we, busy, gnt_id, mem_addr} !== {4'b1010, 8'h10}) begin
      errors++; $display("FAIL fetch_issue got %b/%h exp 1010/10", {mem_re, mem_we, busy, gnt_id}, mem_addr);
    end
    tick();
    checks++;
    if ({mem_re, if_done, d_done} !== 3'b000) begin
      errors++; $display("FAIL fetch_wait got %b exp 000", {mem_re, if_done, d_done});
    end
    tick();
    checks++;
    if ({if_done, d_done} !== 2'b10 || if_rdata !== 16'h1234) begin
      errors++; $display("FAIL fetch_done got %b/%h exp 10/1234", {if_done, d_done}, if_rdata);
    end
    if_req = 0;
    tick();
    checks++;
    if ({if_done, busy} !== 2'b00 || if_rdata !== 16'h1234) begin
      errors++; $display("FAIL fetch_hold got %b/%h exp 00/1234", {if_done, busy}, if_rdata);
    end
  endtask

  task automatic test_store_load;
    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 16'hBEEF;
    tick();
    checks++;
    if ({mem_we, mem_re, gnt_id} !== 3'b101 || mem_addr !== 8'h20 || mem_wdata !== 16'hBEEF) begin
      errors++; $display("FAIL store_issue got %b/%h/%h exp 101/20/beef", {mem_we, mem_re, gnt_id}, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if ({d_done, mem_we, if_done} !== 3'b100) begin
      errors++; $display("FAIL store_done got %b exp 100", {d_done, mem_we, if_done});
    end
    d_req = 0;
    tick();
    d_req = 1; d_we = 0; d_addr = 8'h20;
    tick();
    checks++;
    if ({mem_re, mem_we} !== 2'b10) begin errors++; $display("FAIL load_issue got %b exp 10", {mem_re, mem_we}); end
    tick(); tick();
    checks++;
    if (d_done !== 1'b1 || d_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL load_done got %b/%h exp 1/beef", d_done, d_rdata);
    end
    checks++;
    if (if_rdata !== 16'h1234) begin errors++; $display("FAIL if_rdata_untouched got %h exp 1234", if_rdata); end
    d_req = 0;
    tick();
  endtask

  task automatic test_tie;
    logic exp_id;
    do_reset();
    if_req = 1; if_addr = 8'h10; d_req = 1; d_we = 0; d_addr = 8'h20;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_PORT_ARBITER_DATA_PRIO_EN
      exp_id = 1'b1;
`else
      exp_id = k[0];
`endif
      tick();
      checks++;
      if (gnt_id !== exp_id) begin errors++; $display("FAIL tie_gnt[%0d] got %b exp %b", k, gnt_id, exp_id); end
      tick(); tick();
      checks++;
      if ({if_done, d_done} !== {~exp_id, exp_id}) begin
        errors++; $display("FAIL tie_done[%0d] got %b exp %b", k, {if_done, d_done}, {~exp_id, exp_id});
      end
      tick();
    end
    if_req = 0; d_req = 0;
    tick();
  endtask

  task automatic test_late_arrival;
    if_req = 1; if_addr = 8'h10;
    tick(); tick();
    d_req = 1; d_we = 0; d_addr = 8'h20;
    checks++;
    if (d_done !== 1'b0) begin errors++; $display("FAIL late_wait_ddone got %b exp 0", d_done); end
    tick();
    checks++;
    if ({if_done, d_done, gnt_id} !== 3'b100 || if_rdata !== 16'h1234) begin
      errors++; $display("FAIL late_fetch_done got %b/%h exp 100/1234", {if_done, d_done, gnt_id}, if_rdata);
    end
    if_req = 0;
    tick();
    checks++;
    if ({busy, d_done} !== 2'b00) begin errors++; $display("FAIL late_idle got %b exp 00", {busy, d_done}); end
    tick();
    checks++;
    if ({gnt_id, mem_re} !== 2'b11 || mem_addr !== 8'h20) begin
      errors++; $display("FAIL late_issue got %b/%h exp 11/20", {gnt_id, mem_re}, mem_addr);
    end
    tick(); tick();
    checks++;
    if (d_done !== 1'b1 || d_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL late_data_done got %b/%h exp 1/beef", d_done, d_rdata);
    end
    d_req = 0;
    tick();
  endtask

  task automatic test_lat3;
    if_req3 = 1; if_addr3 = 8'h33;
    tick();
    checks++;
    if (mem_re3 !== 1'b1) begin errors++; $display("FAIL lat3_issue got %b exp 1", mem_re3); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++;
      if ({busy3, if_done3, mem_re3} !== 3'b100 || mem_addr3 !== 8'h33) begin
        errors++; $display("FAIL lat3_wait[%0d] got %b/%h exp 100/33", c, {busy3, if_done3, mem_re3}, mem_addr3);
      end
    end
    tick();
    checks++;
    if (if_done3 !== 1'b1 || if_rdata3 !== 16'hCC33) begin
      errors++; $display("FAIL lat3_done got %b/%h exp 1/cc33", if_done3, if_rdata3);
    end
    if_req3 = 0;
    tick();
    checks++;
    if ({if_done3, busy3} !== 2'b00) begin errors++; $display("FAIL lat3_after got %b exp 00", {if_done3, busy3}); end
  endtask

  task automatic test_reset_abort;
    if_req = 1; if_addr = 8'h10;
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, if_done, mem_re, mem_we} !== 4'b0000 || mem_addr !== 8'h00) begin
      errors++; $display("FAIL abort_now got %b/%h exp 0000/00", {busy, if_done, mem_re, mem_we}, mem_addr);
    end
    if_req = 0;
    tick();
    checks++;
    if ({if_done, d_done, mem_re, mem_we} !== 4'b0000) begin
      errors++; $display("FAIL abort_held got %b exp 0000", {if_done, d_done, mem_re, mem_we});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({busy, if_done} !== 2'b00) begin errors++; $display("FAIL abort_release got %b exp 00", {busy, if_done}); end
    if_req = 1; if_addr = 8'h44;
    tick(); tick(); tick();
    checks++;
    if (if_done !== 1'b1 || if_rdata !== 16'hBB44) begin
      errors++; $display("FAIL abort_reissue got %b/%h exp 1/bb44", if_done, if_rdata);
    end
    if_req = 0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_fetch();
    test_store_load();
    test_tie();
    test_late_arrival();
    test_lat3();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters.
  - Port 0: the instruction-fetch side, read-only (FETCH-state reads).
  - Port 1: the data side, read/write (LOAD/STR in MEMACC).
- Uses a req/done handshake with a round-robin grant.
- Sequences the memory's enable strobes and waits out the fixed memory read latency.
- Sits between the control unit and the memory macro, so a multi-master or pipelined core can share one RAM.

Parameters:
- AW, 8, address width in bits.
- DW, 16, data width (instruction word width).
- MEM_LAT, 1, cycles from the mem_re cycle until mem_rdata is valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  AW  fetch address; stable while if_req is high.
- if_rdata  out  DW  fetch data; valid when if_done=1.
- if_done  out  1  one-cycle completion pulse.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  in  AW  data address; stable while d_req is high.
- d_wdata  in  DW  store data; stable while d_req is high.
- d_rdata  out  DW  load data; valid when d_done=1.
- d_done  out  1  one-cycle completion pulse.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in any state other than IDLE.
- gnt_id  out  1  port owning the current transaction (0 = fetch, 1 = data).

Behaviour:
- Reset: state=IDLE, all outputs 0, last_gnt=1, latency counter 0, capture register 0.
- A reset asserted mid-transaction aborts it: no done pulse, no mem strobe after reset, and requesters re-issue.
- State machine IDLE -> ISSUE -> [WAIT] -> RESP -> IDLE:
  - IDLE: if any req is high, pick a winner. Latch its addr, we (fetch port forces we=0) and wdata into holding registers. Set gnt_id and go to ISSUE. With no request, stay in IDLE.
  - ISSUE (1 cycle): drive mem_addr/mem_wdata from the holding registers, and pulse exactly one of mem_re or mem_we. Write goes to RESP. Read loads the counter with MEM_LAT and goes to WAIT.
  - WAIT: decrement the counter each cycle. In the cycle the counter equals 1, register mem_rdata into the capture register and go to RESP.
  - RESP (1 cycle): assert the winner's done; its rdata port shows the capture register. Go to IDLE.
- mem_addr and mem_wdata hold their value through WAIT; they are 0 in IDLE.
- Latency, counted from the IDLE cycle in which the request is sampled:
  - Read: done in cycle MEM_LAT+2.
  - Write: done in cycle 2.
  - Throughput: one transaction per MEM_LAT+3 cycles for reads, 3 cycles for writes.
- Arbitration: a sole requester always wins. On a tie the port that is not last_gnt wins, and last_gnt updates on each grant.
- A requester must drop req in the cycle after done. A req still high in IDLE is treated as a new request.
- rdata ports hold their last captured value between transactions.
- A port's rdata changes only in its own RESP cycle.
- A req that rises while another transaction is in flight waits; no done is produced for it early.
- A req that drops before done is illegal and has no defined result; an assertion flags it in simulation.
- Exactly one strobe per transaction; mem_re and mem_we are never high together.

Optional Feature:
- Macro MEM_PORT_ARBITER_DATA_PRIO_EN.
  - Defined: on a tie the data port always wins and last_gnt is unused. This avoids stalling LOAD/STR behind fetch.
  - Undefined: round-robin as specified above.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11);
  - port IDs PORT_IF=1'b0 and PORT_DATA=1'b1;
  - the default MEM_LAT.
- One natural sub-module, mem_arb_pick: a combinational two-input winner select. Inputs are if_req, d_req, last_gnt; outputs are a valid flag and the winner id. The prio macro is applied there.

Test Plan:
- Reset, then a single fetch: if_req=1, if_addr=8'h10, memory holds 16'h1234 at 8'h10, MEM_LAT=1 -> mem_re pulses in cycle 1, if_done in cycle 3, if_rdata=16'h1234, d_done stays 0.
- Data store then load: d_we=1, d_addr=8'h20, d_wdata=16'hBEEF -> mem_we one cycle, d_done 2 cycles later. Then a load from 8'h20 -> d_rdata=16'hBEEF.
- Tie after reset: if_req and d_req raised together and held, each re-requesting after done -> grants alternate fetch, data, fetch, data. With MEM_PORT_ARBITER_DATA_PRIO_EN -> data is granted every time.
- Late arrival: d_req rises during fetch WAIT -> fetch completes untouched. The data transaction issues in the IDLE right after RESP; no early d_done.
- MEM_LAT=3 read -> done exactly 5 cycles after the request is sampled, and mem_addr is stable throughout WAIT.
- rst asserted in WAIT -> state IDLE immediately, no done pulse, mem strobes 0. A request re-issued after reset completes normally.
